// File: rtl/ac97_frame_feeder.sv
// Feeds AC'97 slots 1-4: buffers stereo PCM in a FIFO and holds one codec register
// command. Slot words change only on the link's frame strobe so they stay stable while serialized.
module ac97_frame_feeder #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          ac97_bitclk,
  input  logic          rst_b,
  input  logic          ac97_strobe,
  input  logic          pcm_en,
  input  logic          pcm_valid,
  output logic          pcm_ready,
  input  logic [15:0]   pcm_left,
  input  logic [15:0]   pcm_right,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_read,
  input  logic [6:0]    cmd_addr,
  input  logic [15:0]   cmd_data,
  output logic          cmd_done,
  output logic [AW:0]   fifo_level,
  output logic [15:0]   underrun_count,
  output logic [19:0]   ac97_out_slot1,
  output logic          ac97_out_slot1_valid,
  output logic [19:0]   ac97_out_slot2,
  output logic          ac97_out_slot2_valid,
  output logic [19:0]   ac97_out_slot3,
  output logic          ac97_out_slot3_valid,
  output logic [19:0]   ac97_out_slot4,
  output logic          ac97_out_slot4_valid
);

  typedef enum logic [1:0] {IDLE, PEND, SEND} state_e;

  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   LVL_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]   LVL_FULL = {1'b1, {AW{1'b0}}};

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q, level_d;
  logic          pcm_ready_q;
  logic [15:0]   underrun_q;
  logic [19:0]   slot3_q, slot4_q;
  logic          slot3_vld_q, slot4_vld_q;
  logic          push, pop, starve;
  logic [31:0]   head;

  state_e        state_q;
  logic          cmd_rd_q;
  logic [6:0]    cmd_addr_q;
  logic [15:0]   cmd_data_q;
  logic          cmd_ready_q, cmd_done_q;
  logic [19:0]   slot1_q, slot2_q;
  logic          slot1_vld_q, slot2_vld_q;

  assign push   = pcm_valid && pcm_ready_q;
  // Pop decision uses the pre-cycle level, so a sample pushed on a strobe waits a frame.
  assign pop    = ac97_strobe && pcm_en && (level_q != '0);
  assign starve = ac97_strobe && pcm_en && (level_q == '0);
  assign head   = mem_q[rd_ptr_q];

  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + LVL_ONE;
    else if (pop && !push) level_d = level_q - LVL_ONE;
  end

  always_ff @(posedge ac97_bitclk) begin
    if (push) mem_q[wr_ptr_q] <= {pcm_left, pcm_right};
  end

  always_ff @(posedge ac97_bitclk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      pcm_ready_q <= 1'b1;
      underrun_q  <= '0;
      slot3_q     <= '0;
      slot4_q     <= '0;
      slot3_vld_q <= 1'b0;
      slot4_vld_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      level_q     <= level_d;
      pcm_ready_q <= (level_d != LVL_FULL);
      if (starve && underrun_q != 16'hFFFF) underrun_q <= underrun_q + 16'd1;
      if (ac97_strobe) begin
        slot3_q     <= pop ? {head[31:16], 4'h0} : 20'h0;
        slot4_q     <= pop ? {head[15:0], 4'h0}  : 20'h0;
        slot3_vld_q <= pop;
        slot4_vld_q <= pop;
      end
    end
  end

  // Command path: one command is held, sent for exactly one frame, then retired.
  always_ff @(posedge ac97_bitclk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= IDLE;
      cmd_rd_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_data_q  <= '0;
      cmd_ready_q <= 1'b1;
      cmd_done_q  <= 1'b0;
      slot1_q     <= '0;
      slot2_q     <= '0;
      slot1_vld_q <= 1'b0;
      slot2_vld_q <= 1'b0;
    end else begin
      cmd_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            cmd_rd_q    <= cmd_read;
            cmd_addr_q  <= cmd_addr;
            cmd_data_q  <= cmd_data;
            cmd_ready_q <= 1'b0;
            state_q     <= PEND;
          end
        end
        PEND: begin
          if (ac97_strobe) begin
            slot1_q     <= {cmd_rd_q, cmd_addr_q, 12'h0};
            slot1_vld_q <= 1'b1;
            slot2_q     <= cmd_rd_q ? 20'h0 : {cmd_data_q, 4'h0};
            slot2_vld_q <= !cmd_rd_q;
            state_q     <= SEND;
          end
        end
        SEND: begin
          if (ac97_strobe) begin
            slot1_q     <= '0;
            slot2_q     <= '0;
            slot1_vld_q <= 1'b0;
            slot2_vld_q <= 1'b0;
            cmd_done_q  <= 1'b1;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pcm_ready            = pcm_ready_q;
  assign fifo_level           = level_q;
  assign underrun_count       = underrun_q;
  assign cmd_ready            = cmd_ready_q;
  assign cmd_done             = cmd_done_q;
  assign ac97_out_slot1       = slot1_q;
  assign ac97_out_slot1_valid = slot1_vld_q;
  assign ac97_out_slot2       = slot2_q;
  assign ac97_out_slot2_valid = slot2_vld_q;
  assign ac97_out_slot3       = slot3_q;
  assign ac97_out_slot3_valid = slot3_vld_q;
  assign ac97_out_slot4       = slot4_q;
  assign ac97_out_slot4_valid = slot4_vld_q;

endmodule

// File: tb/tb_ac97_frame_feeder.sv
// Directed bench for ac97_frame_feeder: expected frames are queued at each strobe and a
// monitor compares them against the slot outputs presented after that strobe.
module tb_ac97_frame_feeder;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        strobe, pcm_en, pcm_valid, pcm_ready;
  logic [15:0] pcm_left, pcm_right;
  logic        cmd_valid, cmd_ready, cmd_read, cmd_done;
  logic [6:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic [4:0]  fifo_level;
  logic [15:0] underrun_count;
  logic [19:0] s1, s2, s3, s4;
  logic        v1, v2, v3, v4;

  typedef struct packed {
    logic [19:0] s1; logic v1;
    logic [19:0] s2; logic v2;
    logic [19:0] s3; logic v3;
    logic [19:0] s4; logic v4;
    logic        done;
  } frame_t;

  frame_t exp_q[$];
  int     checks = 0;
  int     errors = 0;
  int     done_pulses = 0;
  logic   strb_seen = 1'b0;

  always #5 clk = ~clk;

  ac97_frame_feeder #(.DEPTH(16), .AW(4)) dut (
    .ac97_bitclk(clk), .rst_b(rst_b), .ac97_strobe(strobe), .pcm_en(pcm_en),
    .pcm_valid(pcm_valid), .pcm_ready(pcm_ready), .pcm_left(pcm_left), .pcm_right(pcm_right),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .cmd_done(cmd_done), .fifo_level(fifo_level),
    .underrun_count(underrun_count),
    .ac97_out_slot1(s1), .ac97_out_slot1_valid(v1),
    .ac97_out_slot2(s2), .ac97_out_slot2_valid(v2),
    .ac97_out_slot3(s3), .ac97_out_slot3_valid(v3),
    .ac97_out_slot4(s4), .ac97_out_slot4_valid(v4)
  );

  function automatic frame_t fr(logic [19:0] a1, logic b1, logic [19:0] a2, logic b2,
                                logic [19:0] a3, logic b3, logic [19:0] a4, logic b4, logic d);
    fr = '{s1: a1, v1: b1, s2: a2, v2: b2, s3: a3, v3: b3, s4: a4, v4: b4, done: d};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    strb_seen <= strobe;
    if (cmd_done) done_pulses <= done_pulses + 1;
  end

  // Monitor: the cycle after each strobe edge the slots hold the new frame.
  always @(negedge clk) begin
    if (strb_seen) begin
      frame_t act, exp;
      act = '{s1: s1, v1: v1, s2: s2, v2: v2, s3: s3, v3: v3, s4: s4, v4: v4, done: cmd_done};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL frame: unexpected frame %h with empty queue", act);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          errors++;
          $display("FAIL frame: got %h expected %h", act, exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One strobe cycle followed by one idle cycle, so strobes are never back to back.
  task automatic frame(input frame_t e);
    strobe = 1'b1;
    exp_q.push_back(e);
    tick();
    strobe = 1'b0;
    tick();
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    pcm_valid = 1'b1; pcm_left = l; pcm_right = r;
    tick();
    pcm_valid = 1'b0;
  endtask

  frame_t z;

  initial begin
    z = fr(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_b = 1'b0; strobe = 0; pcm_en = 0; pcm_valid = 0; pcm_left = 0; pcm_right = 0;
    cmd_valid = 0; cmd_read = 0; cmd_addr = 0; cmd_data = 0;
    #23;
    chk("reset_slots", {v1, v2, v3, v4, 28'h0}, 32'h0);
    chk("reset_level", 32'(fifo_level), 32'd0);
    chk("reset_pcm_ready", 32'(pcm_ready), 32'd1);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset_underrun", 32'(underrun_count), 32'd0);
    rst_b = 1'b1;
    tick();

    // Single sample through slots 3/4
    pcm_en = 1'b1;
    push(16'h1234, 16'hABCD);
    chk("level_after_push", 32'(fifo_level), 32'd1);
    frame(fr(0, 0, 0, 0, 20'h12340, 1, 20'hABCD0, 1, 0));
    chk("level_after_pop", 32'(fifo_level), 32'd0);

    // Fill to DEPTH, overflow attempt, pop frees a slot
    for (int i = 0; i < 16; i++) begin
      pcm_valid = 1'b1; pcm_left = 16'h1000 + 16'(i); pcm_right = 16'h2000 + 16'(i);
      tick();
    end
    pcm_left = 16'h1010; pcm_right = 16'h2010;
    chk("full_level", 32'(fifo_level), 32'd16);
    chk("full_ready", 32'(pcm_ready), 32'd0);
    tick();
    chk("full_hold_level", 32'(fifo_level), 32'd16);
    strobe = 1'b1;
    exp_q.push_back(fr(0, 0, 0, 0, 20'h10000, 1, 20'h20000, 1, 0));
    tick();
    strobe = 1'b0;
    chk("pop_full_level", 32'(fifo_level), 32'd15);
    chk("pop_full_ready", 32'(pcm_ready), 32'd1);
    tick();
    pcm_valid = 1'b0;
    chk("refill_level", 32'(fifo_level), 32'd16);
    for (int i = 1; i <= 16; i++)
      frame(fr(0, 0, 0, 0, {16'h1000 + 16'(i), 4'h0}, 1, {16'h2000 + 16'(i), 4'h0}, 1, 0));
    chk("drained_level", 32'(fifo_level), 32'd0);

    // Underrun counting, then disabled playback
    repeat (3) frame(z);
    chk("underrun_3", 32'(underrun_count), 32'd3);
    pcm_en = 1'b0;
    repeat (3) frame(z);
    chk("underrun_disabled", 32'(underrun_count), 32'd3);

    // Push into empty FIFO on a strobe: stored, not popped, counted as underrun
    pcm_en = 1'b1;
    pcm_valid = 1'b1; pcm_left = 16'h7FFF; pcm_right = 16'h8000;
    strobe = 1'b1;
    exp_q.push_back(z);
    tick();
    strobe = 1'b0; pcm_valid = 1'b0;
    tick();
    chk("empty_push_strobe_level", 32'(fifo_level), 32'd1);
    chk("empty_push_strobe_underrun", 32'(underrun_count), 32'd4);
    frame(fr(0, 0, 0, 0, 20'h7FFF0, 1, 20'h80000, 1, 0));
    pcm_en = 1'b0;

    // Write command
    cmd_valid = 1'b1; cmd_read = 1'b0; cmd_addr = 7'h02; cmd_data = 16'h0808;
    tick();
    cmd_valid = 1'b0;
    chk("cmd_ready_pend", 32'(cmd_ready), 32'd0);
    frame(fr(20'h02000, 1, 20'h08080, 1, 0, 0, 0, 0, 0));
    frame(fr(0, 0, 0, 0, 0, 0, 0, 0, 1));
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);

    // Read command accepted on a strobe cycle is not sent in that frame
    cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 7'h26; cmd_data = 16'hFFFF;
    strobe = 1'b1;
    exp_q.push_back(z);
    tick();
    strobe = 1'b0; cmd_valid = 1'b0;
    tick();
    frame(fr(20'hA6000, 1, 20'h00000, 0, 0, 0, 0, 0, 0));
    frame(fr(0, 0, 0, 0, 0, 0, 0, 0, 1));

    // Asynchronous reset while in SEND with a half-full FIFO
    pcm_en = 1'b1;
    for (int i = 0; i < 8; i++) push(16'h3000 + 16'(i), 16'h4000 + 16'(i));
    cmd_valid = 1'b1; cmd_read = 1'b0; cmd_addr = 7'h18; cmd_data = 16'h5555;
    tick();
    cmd_valid = 1'b0;
    frame(fr(20'h18000, 1, 20'h55550, 1, 20'h30000, 1, 20'h40000, 1, 0));
    chk("pre_reset_level", 32'(fifo_level), 32'd7);
    @(negedge clk);
    #2 rst_b = 1'b0;
    #1;
    chk("async_valids", {28'h0, v1, v2, v3, v4}, 32'h0);
    chk("async_level", 32'(fifo_level), 32'd0);
    chk("async_done", 32'(cmd_done), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    tick();
    chk("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("post_reset_pcm_ready", 32'(pcm_ready), 32'd1);
    frame(z);
    chk("post_reset_underrun", 32'(underrun_count), 32'd1);

    repeat (3) tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("cmd_done_pulses", 32'(done_pulses), 32'd2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded bound");
    $fatal(1);
  end

endmodule
